// File: rtl/control_arbiter_if.sv
// control_arbiter_if: request/acknowledge bundle between the input decoders
// (master side) and the control-bank arbiter (slave side).
interface control_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [2*NREQ-1:0]  req_target;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    nack;

  modport master (output req, output req_target, output req_data,
                  input  ack, input  nack);
  modport slave  (input  req, input  req_target, input  req_data,
                  output ack, output nack);
endinterface

// File: rtl/control_arbiter.sv
// control_arbiter: round-robin arbitration of writes into the f/t/m control
// banks. Each grant runs IDLE -> WRITE -> RELEASE; ack/nack and status are
// registered on the WRITE edge.
// Optional feature: define CTRL_ARB_SHADOW_EN to stage writes in per-bank
// shadow registers that reach the live banks only on a commit strobe.
module control_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  control_arbiter_if.slave bus,
  input  logic             commit,
  output logic [DW-1:0]    f_controls,
  output logic [DW-1:0]    t_controls,
  output logic [DW-1:0]    m_controls,
  output logic             busy,
  output logic [2:0]       pending,
  output logic [DW+3:0]    status
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, RELEASE = 2'd2} state_t;

  localparam logic [1:0] LAST_ID = 2'(NREQ - 1);

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr;
  logic [1:0]      pick;
  logic            found;
  int              idx;
  logic [1:0]      win_id_p0;
  logic [1:0]      tgt_p0;
  logic [DW-1:0]   dat_p0;
  logic [NREQ-1:0] ack_d, nack_d;
  logic            wr_en;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, round-robin winner search and the WRITE-cycle responses.
  always_comb begin
    state_d = state_q;
    found   = 1'b0;
    pick    = 2'd0;
    idx     = 0;
    ack_d   = '0;
    nack_d  = '0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (int'(rr_ptr) + k) % NREQ;
          if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = 2'(idx);
          end
        end
        if (found) state_d = WRITE;
      end
      WRITE: begin
        state_d = RELEASE;
        if (tgt_p0 == 2'd3) begin
          nack_d[win_id_p0] = 1'b1;
        end else begin
          ack_d[win_id_p0] = 1'b1;
          wr_en            = 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.req[win_id_p0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, registered handshake pulses, busy and status.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr    <= 2'd0;
      win_id_p0 <= 2'd0;
      tgt_p0    <= 2'd0;
      bus.ack   <= '0;
      bus.nack  <= '0;
      busy      <= 1'b0;
      status    <= '0;
    end else begin
      bus.ack  <= ack_d;
      bus.nack <= nack_d;
      busy     <= (state_d != IDLE);
      if (found) begin
        win_id_p0 <= pick;
        tgt_p0    <= bus.req_target[2*int'(pick) +: 2];
        rr_ptr    <= (pick == LAST_ID) ? 2'd0 : pick + 2'd1;
      end
      if (state_q == WRITE) status <= {win_id_p0, tgt_p0, dat_p0};
    end
  end

  // Winner data capture; only meaningful once a grant has been made.
  always_ff @(posedge clock) begin
    if (found) dat_p0 <= bus.req_data[DW*int'(pick) +: DW];
  end

`ifdef CTRL_ARB_SHADOW_EN
  logic [DW-1:0] f_sh, t_sh, m_sh;

  // Shadow staging: commit publishes pre-edge shadows, a same-edge write stays pending.
  always_ff @(posedge clock) begin
    if (!reset) begin
      f_sh       <= '0;
      t_sh       <= '0;
      m_sh       <= '0;
      f_controls <= '0;
      t_controls <= '0;
      m_controls <= '0;
      pending    <= 3'b000;
    end else begin
      if (commit) begin
        if (pending[0]) f_controls <= f_sh;
        if (pending[1]) t_controls <= t_sh;
        if (pending[2]) m_controls <= m_sh;
        pending <= 3'b000;
      end
      if (wr_en) begin
        case (tgt_p0)
          2'd0:    begin f_sh <= dat_p0; pending[0] <= 1'b1; end
          2'd1:    begin t_sh <= dat_p0; pending[1] <= 1'b1; end
          2'd2:    begin m_sh <= dat_p0; pending[2] <= 1'b1; end
          default: ;
        endcase
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign pending       = 3'b000;

  // Direct writes into the live bank selected by the granted target.
  always_ff @(posedge clock) begin
    if (!reset) begin
      f_controls <= '0;
      t_controls <= '0;
      m_controls <= '0;
    end else if (wr_en) begin
      case (tgt_p0)
        2'd0:    f_controls <= dat_p0;
        2'd1:    t_controls <= dat_p0;
        2'd2:    m_controls <= dat_p0;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_control_arbiter.sv
// tb_control_arbiter: directed stimulus with a response scoreboard for
// control_arbiter. Expected responses are queued when a request is driven
// and popped whenever ack/nack pulses.
module tb_control_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 8;

  logic          clock  = 1'b0;
  logic          reset  = 1'b0;
  logic          commit = 1'b0;
  logic [DW-1:0] f_controls, t_controls, m_controls;
  logic          busy;
  logic [2:0]    pending;
  logic [DW+3:0] status;

  control_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

  control_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .commit     (commit),
    .f_controls (f_controls),
    .t_controls (t_controls),
    .m_controls (m_controls),
    .busy       (busy),
    .pending    (pending),
    .status     (status)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  ack;
    logic [2:0]  nack;
    logic [11:0] status;
    logic [7:0]  f, t, m;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  // Bench model of live banks, shadows and pending flags.
  logic [7:0] mf = 8'h00, mt = 8'h00, mm = 8'h00;
  logic [7:0] sf = 8'h00, st = 8'h00, sm = 8'h00;
  logic [2:0] mp = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mf = 8'h00; mt = 8'h00; mm = 8'h00;
    sf = 8'h00; st = 8'h00; sm = 8'h00;
    mp = 3'b000;
  endtask

  task automatic model_commit();
`ifdef CTRL_ARB_SHADOW_EN
    if (mp[0]) mf = sf;
    if (mp[1]) mt = st;
    if (mp[2]) mm = sm;
    mp = 3'b000;
`endif
  endtask

  task automatic expect_resp(input logic [1:0] id, input logic [1:0] tgt,
                             input logic [7:0] data, input int at_cyc);
    exp_t e;
    e.ack  = 3'b000;
    e.nack = 3'b000;
    if (tgt == 2'd3) begin
      e.nack[id] = 1'b1;
    end else begin
      e.ack[id] = 1'b1;
`ifdef CTRL_ARB_SHADOW_EN
      case (tgt)
        2'd0:    sf = data;
        2'd1:    st = data;
        default: sm = data;
      endcase
      mp[tgt] = 1'b1;
`else
      case (tgt)
        2'd0:    mf = data;
        2'd1:    mt = data;
        default: mm = data;
      endcase
`endif
    end
    e.status = {id, tgt, data};
    e.f      = mf;
    e.t      = mt;
    e.m      = mm;
    e.cyc    = at_cyc;
    sb.push_back(e);
  endtask

  // One clock: sample 1ns after the edge, score any response, and let the
  // acknowledged requester drop its request.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (bus.ack != 3'b000 || bus.nack != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'({bus.ack, bus.nack}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack",       32'(bus.ack),    32'(e.ack));
        chk("nack",      32'(bus.nack),   32'(e.nack));
        chk("status",    32'(status),     32'(e.status));
        chk("f_bank",    32'(f_controls), 32'(e.f));
        chk("t_bank",    32'(t_controls), 32'(e.t));
        chk("m_bank",    32'(m_controls), 32'(e.m));
        chk("ack_cycle", 32'(cyc),        32'(e.cyc));
      end
      bus.req = bus.req & ~(bus.ack | bus.nack);
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset held with every requester asking.
    bus.req        = 3'b111;
    bus.req_target = {2'd2, 2'd1, 2'd0};
    bus.req_data   = {8'h33, 8'h22, 8'h11};
    reset          = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_f",       32'(f_controls), 32'd0);
    chk("rst_t",       32'(t_controls), 32'd0);
    chk("rst_m",       32'(m_controls), 32'd0);
    chk("rst_ack",     32'(bus.ack),    32'd0);
    chk("rst_nack",    32'(bus.nack),   32'd0);
    chk("rst_status",  32'(status),     32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_pending", 32'(pending),    32'd0);

    // Release: grants 0,1,2 in order, acks 3 cycles apart.
    reset = 1'b1;
    expect_resp(2'd0, 2'd0, 8'h11, cyc + 2);
    expect_resp(2'd1, 2'd1, 8'h22, cyc + 5);
    expect_resp(2'd2, 2'd2, 8'h33, cyc + 8);
    drain(20);
    step();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Single write to t from requester 1.
    bus.req_target = {2'd0, 2'd1, 2'd0};
    bus.req_data   = {8'h00, 8'hA5, 8'h00};
    bus.req        = 3'b010;
    expect_resp(2'd1, 2'd1, 8'hA5, cyc + 2);
    step();
    chk("single_busy_write", 32'(busy),    32'd1);
    chk("single_no_ack_yet", 32'(bus.ack), 32'd0);
    drain(5);
    chk("single_status", 32'(status), 32'h5A5);
    step();
    chk("single_ack_pulse", 32'(bus.ack), 32'd0);
    chk("single_busy_idle", 32'(busy),    32'd0);

    // Invalid target from requester 2: nack only, banks untouched.
    bus.req_target = {2'd3, 2'd0, 2'd0};
    bus.req_data   = {8'hFF, 8'h00, 8'h00};
    bus.req        = 3'b100;
    expect_resp(2'd2, 2'd3, 8'hFF, cyc + 2);
    drain(5);
    step();
    chk("inv_nack_pulse", 32'(bus.nack),   32'd0);
    chk("inv_f",          32'(f_controls), 32'(mf));
    chk("inv_t",          32'(t_controls), 32'(mt));
    chk("inv_m",          32'(m_controls), 32'(mm));

    // Commit strobe: ignored without shadows, publishes them with shadows.
    commit = 1'b1;
    model_commit();
    step();
    commit = 1'b0;
    step();
    chk("commit_f",       32'(f_controls), 32'(mf));
    chk("commit_t",       32'(t_controls), 32'(mt));
    chk("commit_m",       32'(m_controls), 32'(mm));
    chk("commit_pending", 32'(pending),    32'(mp));

    // Reset during WRITE aborts: no ack, everything back to 0.
    bus.req_target = {2'd0, 2'd0, 2'd0};
    bus.req_data   = {8'h00, 8'h00, 8'h77};
    bus.req        = 3'b001;
    step();
    chk("abort_busy_in_write", 32'(busy), 32'd1);
    reset = 1'b0;
    step();
    chk("abort_ack",    32'(bus.ack),    32'd0);
    chk("abort_f",      32'(f_controls), 32'd0);
    chk("abort_t",      32'(t_controls), 32'd0);
    chk("abort_m",      32'(m_controls), 32'd0);
    chk("abort_status", 32'(status),     32'd0);
    chk("abort_busy",   32'(busy),       32'd0);
    bus.req = 3'b000;
    model_reset();
    reset = 1'b1;
    step();
    step();
    chk("abort_quiet_ack", 32'(bus.ack), 32'd0);

    // Write f=3C from requester 0 after reset, then a commit pulse.
    bus.req_target = {2'd0, 2'd0, 2'd0};
    bus.req_data   = {8'h00, 8'h00, 8'h3C};
    bus.req        = 3'b001;
    expect_resp(2'd0, 2'd0, 8'h3C, cyc + 2);
    drain(5);
    step();
`ifdef CTRL_ARB_SHADOW_EN
    chk("shadow_f_held",  32'(f_controls), 32'h00);
    chk("shadow_pending", 32'(pending),    32'h1);
`else
    chk("direct_f",         32'(f_controls), 32'h3C);
    chk("direct_pending",   32'(pending),    32'h0);
`endif
    commit = 1'b1;
    model_commit();
    step();
    commit = 1'b0;
    chk("post_commit_f",       32'(f_controls), 32'h3C);
    chk("post_commit_pending", 32'(pending),    32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected $finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
